// File: rtl/mem_port_arbiter_pkg.sv
// Shared settings for the memory port arbiter: data width, requester count,
// FSM state encoding and small select/grant helpers.
package mem_port_arbiter_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int NUM_REQ    = 4;
  localparam int SEL_W      = 2;
  localparam int WDOG_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_FINISH = 2'd2
  } arb_state_e;

  function automatic logic [NUM_REQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

  function automatic logic [SEL_W-1:0] ptr_after(input logic [SEL_W-1:0] idx);
    return idx + SEL_W'(1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set req bit found searching from
// ptr upward, modulo 4.
module rr_pick4
  import mem_port_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   winner,
  output logic               any_req
);

  logic [NUM_REQ-1:0] rot;
  logic [SEL_W-1:0]   offset;

  // rot[k] is the requester k places after ptr, so a fixed-priority search
  // over rot implements the rotating priority.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    assign rot[gi] = req[ptr + SEL_W'(gi)];
  end

  always_comb begin
    offset = '0;
    if (rot[0])      offset = 2'd0;
    else if (rot[1]) offset = 2'd1;
    else if (rot[2]) offset = 2'd2;
    else if (rot[3]) offset = 2'd3;
  end

  assign winner  = ptr + offset;
  assign any_req = |req;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among four requesters, with a
// request/ready handshake, registered outputs and a watchdog abort.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int          WORD_WIDTH     = mem_port_arbiter_pkg::WORD_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    we,
  input  logic                  mem_ready,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  output logic [SEL_W-1:0]      sel,
  output logic [NUM_REQ-1:0]    grant,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [NUM_REQ-1:0]    done,
  output logic [NUM_REQ-1:0]    err,
  output logic [WORD_WIDTH-1:0] rdata
);

  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

  arb_state_e            state_q, state_d;
  logic [SEL_W-1:0]      ptr_q, ptr_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [NUM_REQ-1:0]    done_q, done_d;
  logic [NUM_REQ-1:0]    err_q, err_d;
  logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
  logic [WDOG_W-1:0]     wdog_q, wdog_d;

  logic [SEL_W-1:0]      winner;
  logic                  any_req;

  rr_pick4 u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      sel_q     <= '0;
      grant_q   <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      done_q    <= '0;
      err_q     <= '0;
      rdata_q   <= '0;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      grant_q   <= grant_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      wdog_q    <= wdog_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    grant_d   = grant_q;
    mem_req_d = mem_req_q;
    mem_we_d  = mem_we_q;
    done_d    = '0;
    err_d     = '0;
    rdata_d   = rdata_q;
    wdog_d    = wdog_q;

    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d   = ST_BUSY;
          sel_d     = winner;
          grant_d   = onehot4(winner);
          mem_req_d = 1'b1;
          mem_we_d  = we[winner];
          wdog_d    = '0;
        end
      end

      ST_BUSY: begin
        // Ready wins over an expiring watchdog in the same cycle.
        if (mem_ready) begin
          rdata_d   = mem_rdata;
          done_d    = onehot4(sel_q);
          state_d   = ST_FINISH;
          mem_req_d = 1'b0;
          grant_d   = '0;
          mem_we_d  = 1'b0;
          ptr_d     = ptr_after(sel_q);
        end else if (wdog_q == WDOG_LAST) begin
          err_d     = onehot4(sel_q);
          state_d   = ST_FINISH;
          mem_req_d = 1'b0;
          grant_d   = '0;
          mem_we_d  = 1'b0;
          ptr_d     = ptr_after(sel_q);
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
        wdog_d  = '0;
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        grant_d   = '0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  assign sel     = sel_q;
  assign grant   = grant_q;
  assign mem_req = mem_req_q;
  assign mem_we  = mem_we_q;
  assign done    = done_q;
  assign err     = err_q;
  assign rdata   = rdata_q;

endmodule
